// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT butterfly sequencer.
// Contents: FSM state enum, minimum/default FFT size limits, default
// butterfly latency, stage and block-exponent widths.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned MIN_LOG2N     = 3;
    localparam int unsigned DEF_MAX_LOG2N = 10;
    localparam int unsigned DEF_BFLY_LAT  = 3;
    localparam int unsigned STAGE_W       = 4;
    localparam int unsigned EXP_W         = 4;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Radix-2 DIF butterfly address and twiddle decode for butterfly k of stage s.
// Ports:
//   k       butterfly index within the stage (0 .. N/2-1)
//   s       stage index
//   log2n   FFT size exponent
//   addr_a  upper operand address
//   addr_b  lower operand address (addr_a + half)
//   tw_idx  twiddle ROM index
module fft_bfly_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned TW_W   = 9
) (
    input  logic [ADDR_W-1:0]  k,
    input  logic [STAGE_W-1:0] s,
    input  logic [STAGE_W-1:0] log2n,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic [TW_W-1:0]    tw_idx
);

    logic [STAGE_W-1:0] sh;
    logic [ADDR_W-1:0]  half;
    logic [ADDR_W-1:0]  pos;
    logic [ADDR_W-1:0]  base;

    // half = 2^(log2n-1-s); the group base is grp * 2 * half
    always_comb begin
        sh     = log2n - s - STAGE_W'(1);
        half   = ADDR_W'(1) << sh;
        pos    = k & (half - ADDR_W'(1));
        base   = (k >> sh) << (sh + STAGE_W'(1));
        addr_a = base | pos;
        addr_b = addr_a + half;
        tw_idx = TW_W'(pos << s);
    end

endmodule

// File: rtl/fft_bfly_sequencer.sv
// In-place radix-2 DIF FFT butterfly sequencer for one shared datapath.
// Optional feature macro: FFT_BLOCK_FLOAT_EN (block floating-point scaling).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, log2n          begin an FFT of size 2^log2n (3..MAX_LOG2N)
//   abort                 cancel the current FFT, flush pending writes
//   bfly_ready            datapath accepts an issue this cycle
//   bfly_ovf              datapath overflow, qualified by wr_en
//   rd_valid, rd_addr_a/b, tw_idx   butterfly issue (same-cycle ready qualified)
//   wr_en, wr_addr_a/b    write-back, issue delayed BFLY_LAT cycles
//   stage, busy, done, cfg_err, ovf_sticky   status
//   scale_en, blk_exp     (FFT_BLOCK_FLOAT_EN only) stage scaling and exponent
module fft_bfly_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LOG2N = DEF_MAX_LOG2N,
    parameter int unsigned ADDR_W    = MAX_LOG2N,
    parameter int unsigned BFLY_LAT  = DEF_BFLY_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [STAGE_W-1:0]   log2n,
    input  logic                 abort,
    input  logic                 bfly_ready,
    input  logic                 bfly_ovf,
    output logic                 rd_valid,
    output logic [ADDR_W-1:0]    rd_addr_a,
    output logic [ADDR_W-1:0]    rd_addr_b,
    output logic [MAX_LOG2N-2:0] tw_idx,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr_a,
    output logic [ADDR_W-1:0]    wr_addr_b,
    output logic [STAGE_W-1:0]   stage,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic                 ovf_sticky
`ifdef FFT_BLOCK_FLOAT_EN
    ,
    output logic                 scale_en,
    output logic [EXP_W-1:0]     blk_exp
`endif
);

    localparam int unsigned TW_W  = MAX_LOG2N - 1;
    localparam int unsigned CNT_W = $clog2(BFLY_LAT + 1);

    state_t               state;
    logic [STAGE_W-1:0]   log2n_q;
    logic [STAGE_W-1:0]   s_q;
    logic [ADDR_W-1:0]    k_q;
    logic [CNT_W-1:0]     drain_cnt;
    logic [BFLY_LAT-1:0]  wv;
    logic [ADDR_W-1:0]    wa [BFLY_LAT];
    logic [ADDR_W-1:0]    wb [BFLY_LAT];
`ifdef FFT_BLOCK_FLOAT_EN
    logic                 stage_ovf;
`endif

    logic [ADDR_W-1:0]    ga;
    logic [ADDR_W-1:0]    gb;
    logic [TW_W-1:0]      gtw;
    logic [ADDR_W-1:0]    half_n;
    logic                 run;
    logic                 last_k;
    logic                 last_stage;
    logic                 ovf_hit;
    logic                 start_ok;

    fft_bfly_addr_gen #(
        .ADDR_W (ADDR_W),
        .TW_W   (TW_W)
    ) u_addr_gen (
        .k      (k_q),
        .s      (s_q),
        .log2n  (log2n_q),
        .addr_a (ga),
        .addr_b (gb),
        .tw_idx (gtw)
    );

    // Stage bookkeeping decode
    always_comb begin
        run        = (state == RUN);
        half_n     = ADDR_W'(1) << (log2n_q - STAGE_W'(1));
        last_k     = (k_q == half_n - ADDR_W'(1));
        last_stage = (s_q == log2n_q - STAGE_W'(1));
        ovf_hit    = wr_en & bfly_ovf;
        start_ok   = (log2n >= STAGE_W'(MIN_LOG2N)) && (log2n <= STAGE_W'(MAX_LOG2N));
    end

    // Issue is qualified by ready in the same cycle; addresses idle at zero
    assign rd_valid  = run & bfly_ready;
    assign rd_addr_a = run ? ga  : '0;
    assign rd_addr_b = run ? gb  : '0;
    assign tw_idx    = run ? gtw : '0;
    assign wr_en     = wv[BFLY_LAT-1];
    assign wr_addr_a = wa[BFLY_LAT-1];
    assign wr_addr_b = wb[BFLY_LAT-1];
    assign stage     = s_q;

    // Sequencer FSM, free-running write-back delay line and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            log2n_q    <= '0;
            s_q        <= '0;
            k_q        <= '0;
            drain_cnt  <= '0;
            wv         <= '0;
            for (int i = 0; i < int'(BFLY_LAT); i++) begin
                wa[i] <= '0;
                wb[i] <= '0;
            end
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            ovf_sticky <= 1'b0;
`ifdef FFT_BLOCK_FLOAT_EN
            stage_ovf  <= 1'b0;
            scale_en   <= 1'b0;
            blk_exp    <= '0;
`endif
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;

            // Delay line shifts every cycle, independent of stalls
            wv[0] <= rd_valid;
            wa[0] <= rd_addr_a;
            wb[0] <= rd_addr_b;
            for (int i = 1; i < int'(BFLY_LAT); i++) begin
                wv[i] <= wv[i-1];
                wa[i] <= wa[i-1];
                wb[i] <= wb[i-1];
            end

            if (ovf_hit) begin
                ovf_sticky <= 1'b1;
            end
`ifdef FFT_BLOCK_FLOAT_EN
            if (ovf_hit) begin
                stage_ovf <= 1'b1;
            end
`endif

            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                wv    <= '0;
`ifdef FFT_BLOCK_FLOAT_EN
                scale_en <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (start_ok) begin
                                log2n_q    <= log2n;
                                s_q        <= '0;
                                k_q        <= '0;
                                ovf_sticky <= 1'b0;
                                busy       <= 1'b1;
                                state      <= RUN;
`ifdef FFT_BLOCK_FLOAT_EN
                                stage_ovf  <= 1'b0;
                                scale_en   <= 1'b0;
                                blk_exp    <= '0;
`endif
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bfly_ready) begin
                            if (last_k) begin
                                drain_cnt <= '0;
                                state     <= DRAIN;
                            end else begin
                                k_q <= k_q + ADDR_W'(1);
                            end
                        end
                    end
                    DRAIN: begin
                        // Hold off the next stage until the last write has landed
                        if (drain_cnt == CNT_W'(BFLY_LAT - 1)) begin
                            if (last_stage) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= DONE;
`ifdef FFT_BLOCK_FLOAT_EN
                                scale_en  <= 1'b0;
                                stage_ovf <= 1'b0;
`endif
                            end else begin
                                s_q   <= s_q + STAGE_W'(1);
                                k_q   <= '0;
                                state <= RUN;
`ifdef FFT_BLOCK_FLOAT_EN
                                // Includes an overflow on this cycle's final write
                                scale_en  <= stage_ovf | ovf_hit;
                                stage_ovf <= 1'b0;
                                if (stage_ovf | ovf_hit) begin
                                    blk_exp <= blk_exp + EXP_W'(1);
                                end
`endif
                            end
                        end else begin
                            drain_cnt <= drain_cnt + CNT_W'(1);
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fft_bfly_sequencer.sv
// Self-checking bench for fft_bfly_sequencer (default parameters, BFLY_LAT=3).
module tb_fft_bfly_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] log2n;
    logic       abort;
    logic       bfly_ready;
    logic       bfly_ovf;
    logic       rd_valid;
    logic [9:0] rd_addr_a;
    logic [9:0] rd_addr_b;
    logic [8:0] tw_idx;
    logic       wr_en;
    logic [9:0] wr_addr_a;
    logic [9:0] wr_addr_b;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic       cfg_err;
    logic       ovf_sticky;
`ifdef FFT_BLOCK_FLOAT_EN
    logic       scale_en;
    logic [3:0] blk_exp;
`endif

    fft_bfly_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .log2n      (log2n),
        .abort      (abort),
        .bfly_ready (bfly_ready),
        .bfly_ovf   (bfly_ovf),
        .rd_valid   (rd_valid),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .tw_idx     (tw_idx),
        .wr_en      (wr_en),
        .wr_addr_a  (wr_addr_a),
        .wr_addr_b  (wr_addr_b),
        .stage      (stage),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .ovf_sticky (ovf_sticky)
`ifdef FFT_BLOCK_FLOAT_EN
        ,
        .scale_en   (scale_en),
        .blk_exp    (blk_exp)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int a; int b; int tw; int st; } iss_t;
    typedef struct { int due; int a; int b; } wr_t;

    iss_t iq[$];
    wr_t  wq[$];
    bit   done_due, cfg_due, m_ovf;
    int   cur_st;
    int   rd_cnt, wr_cnt, done_cnt, cfg_cnt, first_wr;
    int   log_a[$], log_b[$], log_tw[$];

    // Classic in-place DIF loop nest: groups of 2*half, twiddle W_N^(p*2^s)
    task automatic load_fft(input int n);
        int nn, half;
        nn = 1 << n;
        for (int s = 0; s < n; s++) begin
            half = nn >> (s + 1);
            for (int g = 0; g < nn / (2 * half); g++)
                for (int p = 0; p < half; p++)
                    iq.push_back(iss_t'{g * 2 * half + p, g * 2 * half + p + half, p << s, s});
        end
    endtask

    always @(negedge clk) begin
        int   outst;
        iss_t it;
        wr_t  w;
        bit   exp_w, dnext, idle_ok, in_range;
        if (rst) begin
            iq.delete();
            wq.delete();
            done_due = 0;
            cfg_due  = 0;
            m_ovf    = 0;
            cur_st   = -1;
        end else begin
            outst = iq.size() + wq.size();
            chk("done", int'(done), int'(done_due));
            chk("cfg_err", int'(cfg_err), int'(cfg_due));
            chk("busy", int'(busy), int'(outst > 0));
            chk("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
            if (done) done_cnt++;
            if (cfg_err) cfg_cnt++;

            if (rd_valid) begin
                rd_cnt++;
                log_a.push_back(int'(rd_addr_a));
                log_b.push_back(int'(rd_addr_b));
                log_tw.push_back(int'(tw_idx));
                if (!bfly_ready) chk("rd_while_stalled", int'(bfly_ready), 1);
                if (iq.size() == 0) begin
                    chk("rd_extra", int'(rd_valid), 0);
                end else begin
                    it = iq.pop_front();
                    if (it.st != cur_st) begin
                        // previous stage must be fully written back
                        chk("raw_hazard", wq.size(), 0);
                        cur_st = it.st;
                    end
                    chk("rd_addr_a", int'(rd_addr_a), it.a);
                    chk("rd_addr_b", int'(rd_addr_b), it.b);
                    chk("tw_idx", int'(tw_idx), it.tw);
                    chk("stage", int'(stage), it.st);
                    wq.push_back(wr_t'{cyc + 3, it.a, it.b});
                end
            end

            exp_w = (wq.size() > 0) && (wq[0].due == cyc);
            chk("wr_en", int'(wr_en), int'(exp_w));
            if (wr_en) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
            end
            dnext = 0;
            if (exp_w) begin
                w = wq.pop_front();
                if (wr_en) begin
                    chk("wr_addr_a", int'(wr_addr_a), w.a);
                    chk("wr_addr_b", int'(wr_addr_b), w.b);
                end
                if (bfly_ovf) m_ovf = 1;
                dnext = (iq.size() == 0) && (wq.size() == 0);
            end

            idle_ok  = start && !abort && (outst == 0) && !done_due;
            in_range = (int'(log2n) >= 3) && (int'(log2n) <= 10);
            cfg_due  = idle_ok && !in_range;
            if (idle_ok && in_range) begin
                load_fft(int'(log2n));
                m_ovf  = 0;
                cur_st = -1;
            end
            if (abort) begin
                iq.delete();
                wq.delete();
                dnext = 0;
            end
            done_due = dnext;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_fft(input int n, input bit toggle, input int ovf_at,
                           output int t0, output int dlat);
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; first_wr = -1;
        log_a.delete(); log_b.delete(); log_tw.delete();
        dlat  = -1;
        start = 1'b1;
        log2n = 4'(n);
        t0    = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20000 && dlat < 0; i++) begin
            if (toggle) bfly_ready = ~bfly_ready;
            bfly_ovf = (ovf_at > 0) && (cyc == t0 + ovf_at);
`ifdef FFT_BLOCK_FLOAT_EN
            if (ovf_at > 0)
                chk("scale_en", int'(scale_en), int'((cyc - t0 >= 8) && (cyc - t0 <= 14)));
`endif
            tick();
            if (done) begin
                dlat = cyc - t0;
                if (ovf_at > 0) chk("ovf_at_done", int'(ovf_sticky), 1);
`ifdef FFT_BLOCK_FLOAT_EN
                if (ovf_at > 0) chk("blk_exp", int'(blk_exp), 1);
`endif
            end
        end
        bfly_ovf   = 1'b0;
        bfly_ready = 1'b1;
        if (dlat < 0) chk("done_timeout", int'(done), 1);
        repeat (3) tick();
        chk("done_pulses", done_cnt, 1);
    endtask

    int lit_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int lit_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int lit_tw[12] = '{0, 1, 2, 3, 0, 2, 0, 2, 0, 0, 0, 0};

    initial begin
        int t0, dlat, wsnap;
        rst = 1'b0; start = 1'b0; abort = 1'b0; log2n = '0;
        bfly_ready = 1'b1; bfly_ovf = 1'b0;
        #1 rst = 1'b1;
        repeat (3) tick();
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_outs", int'(|{rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b,
                                 stage, done, cfg_err, ovf_sticky}), 0);
        rst = 1'b0;
        repeat (2) tick();

        // 8-point unstalled run against hand-derived pairs and latency
        run_fft(3, 1'b0, 0, t0, dlat);
        chk("done_T22", dlat, 22);
        chk("first_wr_lat", first_wr - t0, 4);
        chk("n8_rd_count", rd_cnt, 12);
        chk("n8_wr_count", wr_cnt, 12);
        chk("n8_log_len", log_a.size(), 12);
        for (int i = 0; i < 12 && i < log_a.size(); i++) begin
            chk("lit_addr_a", log_a[i], lit_a[i]);
            chk("lit_addr_b", log_b[i], lit_b[i]);
            chk("lit_tw", log_tw[i], lit_tw[i]);
        end

        // 16-point unstalled latency
        run_fft(4, 1'b0, 0, t0, dlat);
        chk("done_lat_n4", dlat, 1 + 4 * (8 + 3));

        // 1024-point with ready toggling every cycle
        run_fft(10, 1'b1, 0, t0, dlat);
        chk("n1024_rd_count", rd_cnt, 5120);
        chk("n1024_wr_count", wr_cnt, 5120);

        // out-of-range sizes
        cfg_cnt = 0; rd_cnt = 0;
        start = 1'b1; log2n = 4'd2;
        tick();
        log2n = 4'd11;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("cfg_err_count", cfg_cnt, 2);
        chk("cfg_no_rd", rd_cnt, 0);

        // abort during stage 1 of a 16-point run
        done_cnt = 0;
        start = 1'b1; log2n = 4'd4; t0 = cyc;
        tick();
        start = 1'b0;
        while (cyc < t0 + 14) tick();
        chk("abort_stage", int'(stage), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        wsnap = wr_cnt;
        repeat (20) tick();
        chk("abort_no_wr", wr_cnt, wsnap);
        chk("abort_no_done", done_cnt, 0);
        run_fft(3, 1'b0, 0, t0, dlat);
        chk("rerun_lat", dlat, 1 + 3 * (4 + 3));

        // single overflow on the first stage-0 write
        run_fft(3, 1'b0, 4, t0, dlat);
        chk("ovf_hold_after_done", int'(ovf_sticky), 1);

        // asynchronous reset in the middle of a run
        start = 1'b1; log2n = 4'd5;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_rd_valid", int'(rd_valid), 1);
        chk("pre_rst_wr_en", int'(wr_en), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rd_valid", int'(rd_valid), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_wr_en", int'(wr_en), 0);
        chk("async_rst_outs", int'(|{rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b,
                                     stage, done, ovf_sticky}), 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no summary, expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
